// File: rtl/rr_sel_arbiter.sv
// Four-requester round-robin arbiter driving the 2-bit select of a shared one-hot resource.
// Ownership ends on done, request drop, or after MAX_HOLD cycles, followed by a one-cycle gap.
module rr_sel_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
  logic [1:0]       last_owner, last_owner_nx;
  logic [1:0]       sel_nx, winner, idx;
  logic [3:0]       grant_nx;
  logic             busy_nx, timeout_nx, found, req_ok;

  function automatic logic [3:0] decode(input logic [1:0] s);
    case (s)
      2'd0:    decode = 4'b0001;
      2'd1:    decode = 4'b0010;
      2'd2:    decode = 4'b0100;
      default: decode = 4'b1000;
    endcase
  endfunction

  // Evaluates unknown in simulation when any req bit is X/Z, so IDLE refuses to grant.
  assign req_ok = (^req == 1'b0) || (^req == 1'b1);

  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_owner + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    hold_cnt_nx   = hold_cnt;
    last_owner_nx = last_owner;
    grant_nx      = grant;
    sel_nx        = sel;
    busy_nx       = busy;
    timeout_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (found && req_ok) begin
          state_nx      = GRANT;
          sel_nx        = winner;
          grant_nx      = decode(winner);
          busy_nx       = 1'b1;
          hold_cnt_nx   = CNT_ONE;
          last_owner_nx = winner;
        end
      end
      GRANT: begin
        // Owner release outranks the hold limit, so a coincident done never flags timeout.
        if (done[sel] || !req[sel] || (hold_cnt == HOLD_MAX)) begin
          state_nx    = GAP;
          grant_nx    = 4'b0000;
          sel_nx      = 2'd0;
          busy_nx     = 1'b0;
          hold_cnt_nx = '0;
          timeout_nx  = !(done[sel] || !req[sel]);
        end else if (hold_cnt != '1) begin
          hold_cnt_nx = hold_cnt + CNT_ONE;
        end
      end
      GAP: begin
        state_nx = IDLE;
        grant_nx = 4'b0000;
        sel_nx   = 2'd0;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 4'b0000;
        sel_nx   = 2'd0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_owner <= 2'd3;
      grant      <= 4'b0000;
      sel        <= 2'd0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_cnt_nx;
      last_owner <= last_owner_nx;
      grant      <= grant_nx;
      sel        <= sel_nx;
      busy       <= busy_nx;
      timeout    <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter: the driver queues the expected {grant,sel,busy,timeout}
// for each cycle it drives, and a monitor compares them one edge later.
module tb_rr_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;

  rr_sel_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .sel(sel), .busy(busy), .timeout(timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, act=running req=finished");
    $fatal(1, "watchdog");
  end

  always @(posedge clk)
    if (rst_n) assert (!$isunknown(req)) else $error("req carries unknown bits");

  function automatic logic [7:0] o(input logic [3:0] g, input logic [1:0] s,
                                   input logic b, input logic t);
    return {g, s, b, t};
  endfunction

  function automatic logic [7:0] gr(input int k);
    return o(4'(1 << k), 2'(k), 1'b1, 1'b0);
  endfunction

  localparam logic [7:0] IDL = 8'h00;
  localparam logic [7:0] TMO = 8'h01;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act grant=%b sel=%0d busy=%b timeout=%b req grant=%b sel=%0d busy=%b timeout=%b",
               name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // driver: inputs set on the falling edge, result expected after the next rising edge
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [7:0] e,
                      input string name);
    @(negedge clk);
    req  = r;
    done = d;
    exp_q.push_back(e);
    tag_q.push_back(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;
    #2;
    check("reset_state", {grant, sel, busy, timeout}, IDL);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor / scoreboard
  initial begin
    logic [7:0] e;
    string      t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {grant, sel, busy, timeout}, e);
      end
    end
  end

  initial begin
    logic [3:0] oh;
    int         k;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;
    #2;
    check("reset_async", {grant, sel, busy, timeout}, IDL);
    @(negedge clk);
    rst_n = 1'b1;

    // single requester
    step(4'b0001, 4'b0000, gr(0), "single_grant");
    step(4'b0001, 4'b0001, IDL,   "single_gap");
    step(4'b0000, 4'b0000, IDL,   "single_idle");
    step(4'b0000, 4'b0000, IDL,   "single_idle2");

    // round robin, two GRANT cycles per owner; foreign done bits must be ignored
    do_reset();
    for (int n = 0; n < 5; n++) begin
      k  = n % 4;
      oh = 4'(1 << k);
      step(4'b1111, 4'b0000,       gr(k), "rr_grant");
      step(4'b1111, ~oh,           gr(k), "rr_hold_foreign_done");
      step(4'b1111, oh,            IDL,   "rr_gap");
      step(4'b1111, 4'b1111,       IDL,   "rr_gap_to_idle");
    end
    step(4'b0000, 4'b0000, IDL, "rr_quiet");

    // hold limit: last owner 0, req 0100 wins, forced release after 8 cycles
    for (int n = 0; n < 8; n++) step(4'b0100, 4'b0000, gr(2), "hold_grant");
    step(4'b0100, 4'b0000, TMO, "hold_timeout");
    step(4'b0000, 4'b0000, IDL, "hold_timeout_clear");

    // done on the MAX_HOLD edge: search 3,0,1 picks requester 1, no timeout
    for (int n = 0; n < 8; n++) step(4'b0010, 4'b0000, gr(1), "simul_grant");
    step(4'b0010, 4'b0010, IDL, "simul_release_no_timeout");
    step(4'b0000, 4'b0000, IDL, "simul_idle");

    // pointer rotation
    step(4'b0100, 4'b0000, gr(2), "rot_grant2");
    step(4'b0100, 4'b0100, IDL,   "rot_gap");
    step(4'b0000, 4'b0000, IDL,   "rot_idle");
    step(4'b0101, 4'b0000, gr(0), "rot_skip_last_owner");
    step(4'b0101, 4'b0001, IDL,   "rot_gap2");
    step(4'b0100, 4'b0000, IDL,   "rot_idle2");
    step(4'b0100, 4'b0000, gr(2), "rot_sole_requester");
    step(4'b0000, 4'b0000, IDL,   "rot_req_drop_release");
    step(4'b0000, 4'b0000, IDL,   "rot_idle3");

    // reset mid-grant: last owner 2, search 3,0,1 picks requester 1
    step(4'b0010, 4'b0000, gr(1), "mid_grant");
    step(4'b0010, 4'b0000, gr(1), "mid_hold");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check("mid_reset_immediate", {grant, sel, busy, timeout}, IDL);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010, 4'b0000, gr(1), "post_reset_pointer");
    step(4'b1010, 4'b0010, IDL,   "post_reset_gap");
    step(4'b0000, 4'b0000, IDL,   "post_reset_idle");
    step(4'b1000, 4'b0000, gr(3), "post_reset_grant3");
    step(4'b0000, 4'b0000, IDL,   "post_reset_gap3");
    step(4'b0000, 4'b0000, IDL,   "post_reset_idle3");

    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: act pending=%0d req pending=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
